// File: rtl/scmp_microcode_pak.sv
`default_nettype none
// ============================================================================
//  Module      : scmp_microcode_pak (package)
//  Description : Shared types and constants for the SC/MP core slice.
//                Holds the bus-interface state encoding, the bit positions of
//                the status byte the core puts on its data output while
//                ADS_n is low, and helpers that pick that byte apart.
//  Revision    : 1.0 - bus interface state type and status-byte helpers
// ============================================================================
package scmp_microcode_pak;

    // Bus interface unit states.
    typedef enum logic [1:0] {
        BUSIF_IDLE = 2'd0,
        BUSIF_ADDR = 2'd1,
        BUSIF_REQ  = 2'd2,
        BUSIF_DONE = 2'd3
    } BUSIF_STATE_t;

    // Status byte layout: {H, D, I, R, A15, A14, A13, A12}
    localparam int STB_IX_H = 7;    // halt
    localparam int STB_IX_D = 6;    // delay
    localparam int STB_IX_I = 5;    // instruction fetch
    localparam int STB_IX_R = 4;    // read

    // Full 16-bit address: upper nibble from the status byte, lower 12 bits
    // from the core address pins.
    function automatic logic [15:0] busif_full_addr(
        input logic [7:0]  stb,
        input logic [11:0] addr_lo
    );
        return {stb[3:0], addr_lo};
    endfunction

    // Flag nibble {H, D, I, R} extracted by name rather than by slice so the
    // layout stays defined in one place.
    function automatic logic [3:0] busif_stb_flags(input logic [7:0] stb);
        return {stb[STB_IX_H], stb[STB_IX_D], stb[STB_IX_I], stb[STB_IX_R]};
    endfunction

endpackage : scmp_microcode_pak
`default_nettype wire

// File: rtl/scmp_bus_wait_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : scmp_bus_wait_ctr
//  Description : Wait / timeout counter pair for one memory transaction.
//                Both counters clear together and then count the cycles spent
//                waiting for an acknowledge. They saturate rather than wrap.
//  Ports       : clk, rst_n     - clock, async active-low reset
//                clear          - zero both counters (start of a transaction)
//                count_en       - advance both counters this cycle
//                min_reached    - wait count >= MIN_WAIT (ack may be accepted)
//                timeout        - current cycle is the TIMEOUT-th waiting cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module scmp_bus_wait_ctr #(
    parameter int MIN_WAIT = 0,     // 0..15
    parameter int TIMEOUT  = 16     // 2..255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic min_reached,
    output logic timeout
);

    localparam logic [3:0] MIN_WAIT_C = MIN_WAIT[3:0];
    // The count holds the number of waiting cycles already completed, so the
    // TIMEOUT-th cycle is the one in which the count equals TIMEOUT-1.
    localparam logic [7:0] TO_LAST_C  = 8'(TIMEOUT - 1);

    logic [3:0] wait_cnt;
    logic [7:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
            to_cnt   <= 8'd0;
        end else if (clear) begin
            wait_cnt <= 4'd0;
            to_cnt   <= 8'd0;
        end else if (count_en) begin
            if (wait_cnt != 4'hF) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (to_cnt != 8'hFF) begin
                to_cnt <= to_cnt + 8'd1;
            end
        end
    end

    assign min_reached = (wait_cnt >= MIN_WAIT_C);
    assign timeout     = (to_cnt >= TO_LAST_C);

endmodule : scmp_bus_wait_ctr
`default_nettype wire

// File: rtl/scmp_bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : scmp_bus_if
//  Description : SC/MP external bus interface. Demultiplexes the status byte
//                from the core data output during ADS_n, forms the 16-bit
//                address, turns RD_n/WR_n strobes into a single outstanding
//                req/ack memory transaction and stalls the core via cpu_nhold
//                until the transaction completes or times out.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                cpu_addr[11:0]        - core address pins
//                cpu_d_o[7:0]          - core data out / status byte
//                cpu_ads_n/rd_n/wr_n   - core strobes (active low)
//                cpu_d_i[7:0]          - read data back to the core
//                cpu_nhold             - 0 stalls the core
//                mem_addr/req/we/wdata - memory request side
//                mem_rdata, mem_ack    - memory response side
//                st_flags[3:0]         - latched {H,D,I,R}
//                halt_o                - core is in HALT
//                bus_err               - one-cycle error pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module scmp_bus_if
    import scmp_microcode_pak::*;
#(
    parameter int         MIN_WAIT = 0,
    parameter int         TIMEOUT  = 16,
    parameter logic [7:0] ERR_DATA = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_d_o,
    input  logic        cpu_ads_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    output logic [7:0]  cpu_d_i,
    output logic        cpu_nhold,
    output logic [15:0] mem_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [3:0]  st_flags,
    output logic        halt_o,
    output logic        bus_err
);

    BUSIF_STATE_t state;
    BUSIF_STATE_t state_nxt;

    logic [7:0]  cpu_d_i_nxt;
    logic        cpu_nhold_nxt;
    logic [15:0] mem_addr_nxt;
    logic        mem_req_nxt;
    logic        mem_we_nxt;
    logic [7:0]  mem_wdata_nxt;
    logic [3:0]  st_flags_nxt;
    logic        halt_nxt;
    logic        bus_err_nxt;
    logic        latch_addr;

    logic        ctr_clear;
    logic        ctr_en;
    logic        min_reached;
    logic        timeout;

    logic        rd_low;
    logic        wr_low;

    assign rd_low = ~cpu_rd_n;
    assign wr_low = ~cpu_wr_n;
    assign ctr_en = (state == BUSIF_REQ);

    scmp_bus_wait_ctr #(
        .MIN_WAIT (MIN_WAIT),
        .TIMEOUT  (TIMEOUT)
    ) u_wait_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (ctr_clear),
        .count_en    (ctr_en),
        .min_reached (min_reached),
        .timeout     (timeout)
    );

    // ------------------------------------------------------------------
    // State register and registered outputs. Every output is a flop, so
    // nothing reaches the memory side combinationally from the core pins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BUSIF_IDLE;
            cpu_d_i   <= 8'h00;
            cpu_nhold <= 1'b1;
            mem_addr  <= 16'h0000;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            st_flags  <= 4'h0;
            halt_o    <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cpu_d_i   <= cpu_d_i_nxt;
            cpu_nhold <= cpu_nhold_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_wdata <= mem_wdata_nxt;
            st_flags  <= st_flags_nxt;
            halt_o    <= halt_nxt;
            bus_err   <= bus_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        cpu_d_i_nxt   = cpu_d_i;
        cpu_nhold_nxt = cpu_nhold;
        mem_addr_nxt  = mem_addr;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_wdata_nxt = mem_wdata;
        st_flags_nxt  = st_flags;
        halt_nxt      = halt_o;
        bus_err_nxt   = 1'b0;
        latch_addr    = 1'b0;
        ctr_clear     = 1'b0;

        case (state)
            BUSIF_IDLE: begin
                if (!cpu_ads_n) begin
                    latch_addr = 1'b1;
                end
            end

            BUSIF_ADDR: begin
                // A strobe takes priority over a repeated ADS; both strobes
                // together is a core protocol violation and is dropped.
                if (rd_low && wr_low) begin
                    bus_err_nxt = 1'b1;
                    state_nxt   = BUSIF_IDLE;
                end else if (rd_low || wr_low) begin
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = wr_low;
                    if (wr_low) begin
                        mem_wdata_nxt = cpu_d_o;
                    end
                    cpu_nhold_nxt = 1'b0;
                    ctr_clear     = 1'b1;
                    state_nxt     = BUSIF_REQ;
                end else if (!cpu_ads_n) begin
                    latch_addr = 1'b1;
                end
            end

            BUSIF_REQ: begin
                // An ack arriving before the minimum wait is simply ignored;
                // an accepted ack beats a simultaneous timeout.
                if (mem_ack && min_reached) begin
                    mem_req_nxt   = 1'b0;
                    cpu_nhold_nxt = 1'b1;
                    if (!mem_we) begin
                        cpu_d_i_nxt = mem_rdata;
                    end
                    state_nxt = BUSIF_DONE;
                end else if (timeout) begin
                    mem_req_nxt   = 1'b0;
                    cpu_nhold_nxt = 1'b1;
                    if (!mem_we) begin
                        cpu_d_i_nxt = ERR_DATA;
                    end
                    bus_err_nxt = 1'b1;
                    state_nxt   = BUSIF_DONE;
                end
                // A new address strobe while a transaction is outstanding is
                // not latched; it is only flagged.
                if (!cpu_ads_n) begin
                    bus_err_nxt = 1'b1;
                end
            end

            BUSIF_DONE: begin
                if (cpu_rd_n && cpu_wr_n) begin
                    if (!cpu_ads_n) begin
                        latch_addr = 1'b1;
                    end else begin
                        state_nxt = BUSIF_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = BUSIF_IDLE;
            end
        endcase

        // Shared address/status latch used from IDLE, ADDR and DONE.
        if (latch_addr) begin
            mem_addr_nxt = busif_full_addr(cpu_d_o, cpu_addr);
            st_flags_nxt = busif_stb_flags(cpu_d_o);
            halt_nxt     = cpu_d_o[STB_IX_H];
            state_nxt    = BUSIF_ADDR;
        end
    end

endmodule : scmp_bus_if
`default_nettype wire

// File: tb/tb_scmp_bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scmp_bus_if
//  Description : Self-checking bench for scmp_bus_if. Two instances are
//                built (MIN_WAIT 0 and 3, TIMEOUT 16) with independent
//                stimulus. Each transaction task derives the expected
//                output timeline from the bus rules (acceptance cycle,
//                timeout cycle) and a per-cycle compare process checks all
//                outputs of both instances against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scmp_bus_if;

    localparam int         NU   = 2;
    localparam int         TO   = 16;
    localparam logic [7:0] ERRD = 8'hFF;

    function automatic int mw_of(input int u);
        return (u == 0) ? 0 : 3;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [11:0] cpu_addr  [NU];
    logic [7:0]  cpu_d_o   [NU];
    logic        cpu_ads_n [NU];
    logic        cpu_rd_n  [NU];
    logic        cpu_wr_n  [NU];
    logic [7:0]  cpu_d_i   [NU];
    logic        cpu_nhold [NU];
    logic [15:0] mem_addr  [NU];
    logic        mem_req   [NU];
    logic        mem_we    [NU];
    logic [7:0]  mem_wdata [NU];
    logic [7:0]  mem_rdata [NU];
    logic        mem_ack   [NU];
    logic [3:0]  st_flags  [NU];
    logic        halt_o    [NU];
    logic        bus_err   [NU];

    for (genvar g = 0; g < NU; g++) begin : g_dut
        scmp_bus_if #(
            .MIN_WAIT ((g == 0) ? 0 : 3),
            .TIMEOUT  (TO),
            .ERR_DATA (ERRD)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .cpu_addr  (cpu_addr[g]),
            .cpu_d_o   (cpu_d_o[g]),
            .cpu_ads_n (cpu_ads_n[g]),
            .cpu_rd_n  (cpu_rd_n[g]),
            .cpu_wr_n  (cpu_wr_n[g]),
            .cpu_d_i   (cpu_d_i[g]),
            .cpu_nhold (cpu_nhold[g]),
            .mem_addr  (mem_addr[g]),
            .mem_req   (mem_req[g]),
            .mem_we    (mem_we[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .mem_ack   (mem_ack[g]),
            .st_flags  (st_flags[g]),
            .halt_o    (halt_o[g]),
            .bus_err   (bus_err[g])
        );
    end

    typedef struct packed {
        logic [7:0]  d_i;
        logic        nhold;
        logic [15:0] addr;
        logic        req;
        logic        we;
        logic [7:0]  wdata;
        logic [3:0]  flags;
        logic        halt;
        logic        err;
    } exp_t;

    exp_t exp_o [NU];
    logic chk_en;
    int   checks   = 0;
    int   failures = 0;
    int   nhold_low [NU];
    int   req_high  [NU];
    int   err_cnt   [NU];

    function automatic exp_t reset_exp();
        exp_t e;
        e       = '0;
        e.nhold = 1'b1;
        return e;
    endfunction

    task automatic check(input string name, input int u,
                         input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s u%0d t=%0t actual=%h required=%h", name, u, $time, act, req);
        end
    endtask

    // Per-cycle compare against the expected timeline, away from the edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < NU; u++) begin
                check("cpu_d_i",   u, 16'(cpu_d_i[u]),   16'(exp_o[u].d_i));
                check("cpu_nhold", u, 16'(cpu_nhold[u]), 16'(exp_o[u].nhold));
                check("mem_addr",  u, mem_addr[u],       exp_o[u].addr);
                check("mem_req",   u, 16'(mem_req[u]),   16'(exp_o[u].req));
                check("mem_we",    u, 16'(mem_we[u]),    16'(exp_o[u].we));
                check("mem_wdata", u, 16'(mem_wdata[u]), 16'(exp_o[u].wdata));
                check("st_flags",  u, 16'(st_flags[u]),  16'(exp_o[u].flags));
                check("halt_o",    u, 16'(halt_o[u]),    16'(exp_o[u].halt));
                check("bus_err",   u, 16'(bus_err[u]),   16'(exp_o[u].err));
                if (!cpu_nhold[u]) nhold_low[u]++;
                if (mem_req[u])    req_high[u]++;
                if (bus_err[u])    err_cnt[u]++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle(input int u);
        cpu_addr[u]  = 12'h000;
        cpu_d_o[u]   = 8'h00;
        cpu_ads_n[u] = 1'b1;
        cpu_rd_n[u]  = 1'b1;
        cpu_wr_n[u]  = 1'b1;
        mem_rdata[u] = 8'h00;
        mem_ack[u]   = 1'b0;
    endtask

    // Address strobe cycle: latch address and flags.
    task automatic do_ads(input int u, input logic [7:0] st, input logic [11:0] a);
        cpu_ads_n[u] = 1'b0;
        cpu_d_o[u]   = st;
        cpu_addr[u]  = a;
        step();
        exp_o[u].addr  = {st[3:0], a};
        exp_o[u].flags = st[7:4];
        exp_o[u].halt  = st[7];
        exp_o[u].err   = 1'b0;
        cpu_ads_n[u]   = 1'b1;
    endtask

    // Read or write strobe: the request and the stall start together.
    task automatic do_strobe(input int u, input logic is_wr, input logic [7:0] wd);
        if (is_wr) begin
            cpu_wr_n[u] = 1'b0;
            cpu_d_o[u]  = wd;
        end else begin
            cpu_rd_n[u] = 1'b0;
            cpu_d_o[u]  = 8'h00;
        end
        step();
        exp_o[u].req   = 1'b1;
        exp_o[u].we    = is_wr;
        if (is_wr) exp_o[u].wdata = wd;
        exp_o[u].nhold = 1'b0;
        exp_o[u].err   = 1'b0;
    endtask

    // Waiting phase. Bit k of ack_mask offers an ack in waiting cycle k
    // (k = 1..TO). ads_k != 0 raises a stray ADS in that waiting cycle.
    task automatic do_req(input int u, input logic [31:0] ack_mask,
                          input logic [7:0] rd, input int ads_k);
        int   acc;
        logic tmo;
        acc = 0;
        for (int k = 1; k <= TO; k++) begin
            if (acc == 0 && ack_mask[k] && (k - 1) >= mw_of(u)) acc = k;
        end
        tmo = (acc == 0);
        if (tmo) acc = TO;
        for (int k = 1; k <= acc; k++) begin
            mem_ack[u]   = ack_mask[k];
            mem_rdata[u] = (k == acc && !tmo) ? rd : ~rd;
            cpu_ads_n[u] = (k == ads_k) ? 1'b0 : 1'b1;
            if (k == ads_k) begin
                cpu_d_o[u]  = 8'hC7;
                cpu_addr[u] = 12'h999;
            end
            step();
            exp_o[u].err = (k == ads_k) || (k == acc && tmo);
            if (k == acc) begin
                exp_o[u].req   = 1'b0;
                exp_o[u].nhold = 1'b1;
                if (!exp_o[u].we) exp_o[u].d_i = tmo ? ERRD : rd;
            end
        end
        mem_ack[u]   = 1'b0;
        cpu_ads_n[u] = 1'b1;
    endtask

    // Hold the strobe one more cycle, then release it (optionally with ADS).
    task automatic do_release(input int u, input logic ads,
                              input logic [7:0] st, input logic [11:0] a);
        step();
        exp_o[u].err = 1'b0;
        cpu_rd_n[u] = 1'b1;
        cpu_wr_n[u] = 1'b1;
        if (ads) begin
            cpu_ads_n[u] = 1'b0;
            cpu_d_o[u]   = st;
            cpu_addr[u]  = a;
        end
        step();
        if (ads) begin
            exp_o[u].addr  = {st[3:0], a};
            exp_o[u].flags = st[7:4];
            exp_o[u].halt  = st[7];
        end
        cpu_ads_n[u] = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        chk_en = 1'b0;
        for (int u = 0; u < NU; u++) begin
            set_idle(u);
            exp_o[u]     = reset_exp();
            nhold_low[u] = 0;
            req_high[u]  = 0;
            err_cnt[u]   = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < NU; u++) begin
            check("rst_nhold", u, 16'(cpu_nhold[u]), 16'd1);
            check("rst_req",   u, 16'(mem_req[u]),   16'd0);
            check("rst_d_i",   u, 16'(cpu_d_i[u]),   16'h00);
            check("rst_addr",  u, mem_addr[u],       16'h0000);
            check("rst_err",   u, 16'(bus_err[u]),   16'd0);
        end
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step();

        // Read, ack offered in the third waiting cycle.
        do_ads(0, 8'h13, 12'h456);
        nhold_low[0] = 0;
        do_strobe(0, 1'b0, 8'h00);
        do_req(0, 32'h1 << 3, 8'hA5, 0);
        do_release(0, 1'b0, 8'h00, 12'h000);
        step();
        check("rd_addr",  0, mem_addr[0],        16'h3456);
        check("rd_flags", 0, 16'(st_flags[0]),   16'h1);
        check("rd_we",    0, 16'(mem_we[0]),     16'd0);
        check("rd_d_i",   0, 16'(cpu_d_i[0]),    16'hA5);
        check("rd_stall", 0, 16'(nhold_low[0]),  16'd3);

        // Write: read data register must not change.
        do_ads(0, 8'h0F, 12'hFFF);
        do_strobe(0, 1'b1, 8'h5A);
        do_req(0, 32'h1 << 1, 8'h33, 0);
        do_release(0, 1'b0, 8'h00, 12'h000);
        step();
        check("wr_addr",  0, mem_addr[0],        16'hFFFF);
        check("wr_we",    0, 16'(mem_we[0]),     16'd1);
        check("wr_wdata", 0, 16'(mem_wdata[0]),  16'h5A);
        check("wr_d_i",   0, 16'(cpu_d_i[0]),    16'hA5);

        // MIN_WAIT=3: early ack in cycle 1 ignored, ack in cycle 4 accepted.
        do_ads(1, 8'h21, 12'h0AB);
        req_high[1] = 0;
        do_strobe(1, 1'b0, 8'h00);
        do_req(1, (32'h1 << 1) | (32'h1 << 4), 8'h3C, 0);
        do_release(1, 1'b0, 8'h00, 12'h000);
        step();
        check("mw_req_cycles", 1, 16'(req_high[1]), 16'd4);
        check("mw_d_i",        1, 16'(cpu_d_i[1]),  16'h3C);

        // Timeout with no ack.
        do_ads(0, 8'h02, 12'h010);
        req_high[0] = 0;
        err_cnt[0]  = 0;
        do_strobe(0, 1'b0, 8'h00);
        do_req(0, 32'h0, 8'h00, 0);
        do_release(0, 1'b0, 8'h00, 12'h000);
        step();
        check("to_req_cycles", 0, 16'(req_high[0]),  16'd16);
        check("to_err_pulses", 0, 16'(err_cnt[0]),   16'd1);
        check("to_d_i",        0, 16'(cpu_d_i[0]),   16'hFF);
        check("to_nhold",      0, 16'(cpu_nhold[0]), 16'd1);

        // Ack in the last waiting cycle: ack beats timeout, no error.
        do_ads(1, 8'h04, 12'h321);
        err_cnt[1] = 0;
        do_strobe(1, 1'b0, 8'h00);
        do_req(1, 32'h1 << 16, 8'h6E, 0);
        do_release(1, 1'b0, 8'h00, 12'h000);
        step();
        check("race_d_i", 1, 16'(cpu_d_i[1]), 16'h6E);
        check("race_err", 1, 16'(err_cnt[1]), 16'd0);

        // Halt set, held through a read, cleared by ADS during strobe release;
        // then a write with a stray ADS in its first waiting cycle.
        do_ads(0, 8'h80, 12'h123);
        do_strobe(0, 1'b0, 8'h00);
        do_req(0, 32'h1 << 2, 8'h17, 0);
        check("halt_held", 0, 16'(halt_o[0]), 16'd1);
        do_release(0, 1'b1, 8'h00, 12'h777);
        do_strobe(0, 1'b1, 8'h44);
        do_req(0, 32'h1 << 1, 8'h00, 1);
        do_release(0, 1'b0, 8'h00, 12'h000);
        step();
        check("halt_clr",  0, 16'(halt_o[0]),  16'd0);
        check("halt_addr", 0, mem_addr[0],     16'h0777);

        // Re-latch in ADDR: second ADS wins.
        do_ads(1, 8'h5A, 12'h111);
        do_ads(1, 8'h63, 12'h222);
        do_strobe(1, 1'b0, 8'h00);
        do_req(1, 32'h1 << 5, 8'h81, 0);
        do_release(1, 1'b0, 8'h00, 12'h000);
        step();
        check("relatch_addr",  1, mem_addr[1],       16'h3222);
        check("relatch_flags", 1, 16'(st_flags[1]),  16'h6);

        // Both strobes low in ADDR: error pulse, no request.
        do_ads(0, 8'h01, 12'h001);
        req_high[0] = 0;
        cpu_rd_n[0] = 1'b0;
        cpu_wr_n[0] = 1'b0;
        step();
        exp_o[0].err = 1'b1;
        cpu_rd_n[0] = 1'b1;
        cpu_wr_n[0] = 1'b1;
        step();
        exp_o[0].err = 1'b0;
        step();
        check("proto_no_req", 0, 16'(req_high[0]), 16'd0);

        // Asynchronous reset in the middle of a request.
        do_ads(0, 8'h9C, 12'hABC);
        do_strobe(0, 1'b0, 8'h00);
        step();
        check("pre_rst_req", 0, 16'(mem_req[0]), 16'd1);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("arst_req",   0, 16'(mem_req[0]),   16'd0);
        check("arst_nhold", 0, 16'(cpu_nhold[0]), 16'd1);
        check("arst_addr",  0, mem_addr[0],       16'h0000);
        check("arst_d_i",   0, 16'(cpu_d_i[0]),   16'h00);
        check("arst_flags", 0, 16'(st_flags[0]),  16'h0);
        check("arst_halt",  0, 16'(halt_o[0]),    16'd0);
        check("arst_wdata", 0, 16'(mem_wdata[0]), 16'h00);
        check("arst_we",    0, 16'(mem_we[0]),    16'd0);
        for (int u = 0; u < NU; u++) begin
            set_idle(u);
            exp_o[u] = reset_exp();
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_scmp_bus_if
`default_nettype wire
